// File: rtl/mc_pkg.sv
`default_nettype none
// ============================================================================
// Module : mc_pkg
// Shared encodings and constants for the multicycle MIPS datapath slice.
// Rev    : 1.0  initial release
// ============================================================================
package mc_pkg;

  typedef enum logic [1:0] {
    SRCB_REG     = 2'b00,
    SRCB_FOUR    = 2'b01,
    SRCB_IMM     = 2'b10,
    SRCB_IMM_SH2 = 2'b11
  } alu_src_b_e;

  typedef enum logic [1:0] {
    PCS_ALU    = 2'b00,
    PCS_ALUOUT = 2'b01,
    PCS_JUMP   = 2'b10,
    PCS_RSVD   = 2'b11
  } pc_source_e;

  localparam logic [5:0] RTYPE = 6'b000000;
  localparam logic [5:0] LW    = 6'b100011;
  localparam logic [5:0] SW    = 6'b101011;
  localparam logic [5:0] BEQ   = 6'b000100;
  localparam logic [5:0] J     = 6'b000010;
  localparam logic [5:0] HALT  = 6'b111111;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  function automatic logic [31:0] sext16(input logic [15:0] v);
    return {{16{v[15]}}, v};
  endfunction

endpackage
`default_nettype wire

// File: rtl/mc_datapath_regs_if.sv
`default_nettype none
// ============================================================================
// Module : mc_datapath_regs_if
// Control strobes, memory/ALU/register-file buses of the multicycle datapath.
// Rev    : 1.0  initial release
// ============================================================================
interface mc_datapath_regs_if;

  logic        pc_write;
  logic        pc_write_cond;
  logic        ir_write;
  logic        iord;
  logic        mem_read;
  logic        mem_write;
  logic        mem_to_reg;
  logic        reg_dst;
  logic        reg_write;
  logic        alu_src_a;
  logic [1:0]  alu_src_b;
  logic [1:0]  pc_source;
  logic [31:0] mem_rdata;
  logic [31:0] alu_result;
  logic        alu_zero;
  logic [31:0] rs_data;
  logic [31:0] rt_data;

  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_rd;
  logic        mem_wr;
  logic [31:0] alu_a;
  logic [31:0] alu_b;
  logic [4:0]  rs_addr;
  logic [4:0]  rt_addr;
  logic [4:0]  wb_addr;
  logic [31:0] wb_data;
  logic        wb_en;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc;
  logic [31:0] instr_cnt;
  logic        halted;

  modport master (
    output pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           mem_rdata, alu_result, alu_zero, rs_data, rt_data,
    input  mem_addr, mem_wdata, mem_rd, mem_wr, alu_a, alu_b, rs_addr,
           rt_addr, wb_addr, wb_data, wb_en, opcode, funct, pc, instr_cnt,
           halted
  );

  modport slave (
    input  pc_write, pc_write_cond, ir_write, iord, mem_read, mem_write,
           mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, pc_source,
           mem_rdata, alu_result, alu_zero, rs_data, rt_data,
    output mem_addr, mem_wdata, mem_rd, mem_wr, alu_a, alu_b, rs_addr,
           rt_addr, wb_addr, wb_data, wb_en, opcode, funct, pc, instr_cnt,
           halted
  );

endinterface
`default_nettype wire

// File: rtl/mc_pc_unit.sv
`default_nettype none
// ============================================================================
// Module : mc_pc_unit
// Program counter with conditional-write enable, next-PC mux and halt gating.
// Rev    : 1.0  initial release
// ============================================================================
module mc_pc_unit
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT
) (
  input  wire logic        clk,
  input  wire logic        rst,
  input  wire logic        pc_write_i,
  input  wire logic        pc_write_cond_i,
  input  wire logic        alu_zero_i,
  input  wire logic        halted_i,
  input  wire logic [1:0]  pc_source_i,
  input  wire logic [31:0] alu_result_i,
  input  wire logic [31:0] alu_out_i,
  input  wire logic [25:0] jump_idx_i,
  output logic      [31:0] pc_o
);

  logic [31:0] pc_q;
  logic [31:0] pc_d;
  logic [31:0] target;
  logic        target_ok;
  logic        pc_en;

  always_comb begin
    pc_en     = (pc_write_i | (pc_write_cond_i & alu_zero_i)) & ~halted_i;
    target    = alu_result_i;
    target_ok = 1'b1;
    case (pc_source_e'(pc_source_i))
      PCS_ALU:    target = alu_result_i;
      PCS_ALUOUT: target = alu_out_i;
      PCS_JUMP:   target = {pc_q[31:28], jump_idx_i, 2'b00};
      default:    target_ok = 1'b0;
    endcase
    // Reserved select holds the PC; loaded values are always word aligned.
    pc_d = pc_q;
    if (pc_en && target_ok) begin
      pc_d = {target[31:2], 2'b00};
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q <= RESET_PC;
    end else begin
      pc_q <= pc_d;
    end
  end

  assign pc_o = pc_q;

endmodule
`default_nettype wire

// File: rtl/mc_datapath_regs.sv
`default_nettype none
// ============================================================================
// Module : mc_datapath_regs
// Multicycle MIPS datapath registers (PC, IR, MDR, A, B, ALUOut) and muxes.
// Optional macro HALT_EN enables the sticky HALT_OP halt state.
// Rev    : 1.0  initial release
// ============================================================================
module mc_datapath_regs
  import mc_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [5:0]  HALT_OP  = HALT
) (
  input  wire logic         clk,
  input  wire logic         rst,
  mc_datapath_regs_if.slave bus
);

  logic [31:0] pc;
  logic [31:0] ir_q,  ir_d;
  logic [31:0] mdr_q, mdr_d;
  logic [31:0] a_q;
  logic [31:0] b_q;
  logic [31:0] alu_out_q;
  logic [31:0] instr_cnt_q, instr_cnt_d;
  logic        halted;
  logic [31:0] imm_ext;
  logic [4:0]  wb_addr;

`ifdef HALT_EN
  logic halted_q;
  logic halted_d;

  // Sets one edge after IR holds the halt opcode; only reset clears it.
  assign halted_d = halted_q | (ir_q[31:26] == HALT_OP);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      halted_q <= 1'b0;
    end else begin
      halted_q <= halted_d;
    end
  end

  assign halted = halted_q;
`else
  assign halted = 1'b0;
`endif

  mc_pc_unit #(
    .RESET_PC (RESET_PC)
  ) u_pc_unit (
    .clk             (clk),
    .rst             (rst),
    .pc_write_i      (bus.pc_write),
    .pc_write_cond_i (bus.pc_write_cond),
    .alu_zero_i      (bus.alu_zero),
    .halted_i        (halted),
    .pc_source_i     (bus.pc_source),
    .alu_result_i    (bus.alu_result),
    .alu_out_i       (alu_out_q),
    .jump_idx_i      (ir_q[25:0]),
    .pc_o            (pc)
  );

  always_comb begin
    ir_d        = ir_q;
    instr_cnt_d = instr_cnt_q;
    if (bus.ir_write && !halted) begin
      ir_d        = bus.mem_rdata;
      instr_cnt_d = instr_cnt_q + 32'd1;
    end
    mdr_d = (bus.mem_read && bus.iord) ? bus.mem_rdata : mdr_q;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      ir_q        <= 32'd0;
      mdr_q       <= 32'd0;
      a_q         <= 32'd0;
      b_q         <= 32'd0;
      alu_out_q   <= 32'd0;
      instr_cnt_q <= 32'd0;
    end else begin
      ir_q        <= ir_d;
      mdr_q       <= mdr_d;
      a_q         <= bus.rs_data;
      b_q         <= bus.rt_data;
      alu_out_q   <= bus.alu_result;
      instr_cnt_q <= instr_cnt_d;
    end
  end

  assign bus.mem_addr  = bus.iord ? alu_out_q : pc;
  assign bus.mem_wdata = b_q;
  assign bus.mem_rd    = bus.mem_read  & ~halted;
  assign bus.mem_wr    = bus.mem_write & ~halted;

  assign imm_ext = sext16(ir_q[15:0]);

  always_comb begin
    bus.alu_b = b_q;
    case (alu_src_b_e'(bus.alu_src_b))
      SRCB_REG:     bus.alu_b = b_q;
      SRCB_FOUR:    bus.alu_b = 32'd4;
      SRCB_IMM:     bus.alu_b = imm_ext;
      SRCB_IMM_SH2: bus.alu_b = {imm_ext[29:0], 2'b00};
      default:      bus.alu_b = b_q;
    endcase
  end

  assign bus.alu_a = bus.alu_src_a ? a_q : pc;

  // Writes to $zero are suppressed here so the register file needs no check.
  assign wb_addr       = bus.reg_dst ? ir_q[15:11] : ir_q[20:16];
  assign bus.wb_addr   = wb_addr;
  assign bus.wb_data   = bus.mem_to_reg ? mdr_q : alu_out_q;
  assign bus.wb_en     = bus.reg_write & ~halted & (wb_addr != 5'd0);

  assign bus.rs_addr   = ir_q[25:21];
  assign bus.rt_addr   = ir_q[20:16];
  assign bus.opcode    = ir_q[31:26];
  assign bus.funct     = ir_q[5:0];
  assign bus.pc        = pc;
  assign bus.instr_cnt = instr_cnt_q;
  assign bus.halted    = halted;

endmodule
`default_nettype wire

// File: tb/tb_mc_datapath_regs.sv
`default_nettype none
// ============================================================================
// Module : tb_mc_datapath_regs
// Directed plus random checks of mc_datapath_regs against a behavioural model.
// Rev    : 1.0  initial release
// ============================================================================
module tb_mc_datapath_regs;
  import mc_pkg::*;

  localparam logic [31:0] RST_PC = 32'h0000_0000;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  mc_datapath_regs_if bus ();

  mc_datapath_regs #(
    .RESET_PC (RST_PC),
    .HALT_OP  (6'b111111)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_err    = 0;

  // Architectural model state
  logic [31:0] m_pc, m_ir, m_mdr, m_a, m_b, m_ao, m_cnt;
  logic        m_halt;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
  endtask

  task automatic model_reset();
    m_pc = RST_PC; m_ir = 0; m_mdr = 0; m_a = 0; m_b = 0; m_ao = 0; m_cnt = 0;
    m_halt = 1'b0;
  endtask

  task automatic set_idle();
    bus.pc_write = 0; bus.pc_write_cond = 0; bus.ir_write = 0; bus.iord = 0;
    bus.mem_read = 0; bus.mem_write = 0; bus.mem_to_reg = 0; bus.reg_dst = 0;
    bus.reg_write = 0; bus.alu_src_a = 0; bus.alu_src_b = 2'b00;
    bus.pc_source = 2'b00; bus.mem_rdata = 0; bus.alu_result = 0;
    bus.alu_zero = 0; bus.rs_data = 0; bus.rt_data = 0;
  endtask

  task automatic check_all(input string tag);
    logic [31:0] imm, e_b;
    logic [4:0]  e_wa;
    imm = {{16{m_ir[15]}}, m_ir[15:0]};
    case (bus.alu_src_b)
      2'd0:    e_b = m_b;
      2'd1:    e_b = 32'd4;
      2'd2:    e_b = imm;
      default: e_b = imm * 4;
    endcase
    e_wa = bus.reg_dst ? m_ir[15:11] : m_ir[20:16];
    chk({tag, ".pc"},        bus.pc,        m_pc);
    chk({tag, ".instr_cnt"}, bus.instr_cnt, m_cnt);
    chk({tag, ".halted"},    32'(bus.halted), 32'(m_halt));
    chk({tag, ".opcode"},    32'(bus.opcode), 32'(m_ir[31:26]));
    chk({tag, ".funct"},     32'(bus.funct),  32'(m_ir[5:0]));
    chk({tag, ".rs_addr"},   32'(bus.rs_addr), 32'(m_ir[25:21]));
    chk({tag, ".rt_addr"},   32'(bus.rt_addr), 32'(m_ir[20:16]));
    chk({tag, ".mem_addr"},  bus.mem_addr,  bus.iord ? m_ao : m_pc);
    chk({tag, ".mem_wdata"}, bus.mem_wdata, m_b);
    chk({tag, ".mem_rd"},    32'(bus.mem_rd), 32'(bus.mem_read && !m_halt));
    chk({tag, ".mem_wr"},    32'(bus.mem_wr), 32'(bus.mem_write && !m_halt));
    chk({tag, ".alu_a"},     bus.alu_a,     bus.alu_src_a ? m_a : m_pc);
    chk({tag, ".alu_b"},     bus.alu_b,     e_b);
    chk({tag, ".wb_addr"},   32'(bus.wb_addr), 32'(e_wa));
    chk({tag, ".wb_data"},   bus.wb_data,   bus.mem_to_reg ? m_mdr : m_ao);
    chk({tag, ".wb_en"},     32'(bus.wb_en), 32'(bus.reg_write && !m_halt && e_wa != 0));
  endtask

  // Check outputs with the current inputs, clock one edge, update model, recheck.
  task automatic step(input string tag);
    logic [31:0] n_pc, n_ir, n_mdr, n_cnt;
    logic        n_halt;
    #1;
    check_all({tag, "/pre"});
    n_pc = m_pc; n_ir = m_ir; n_mdr = m_mdr; n_cnt = m_cnt;
    if (!m_halt && (bus.pc_write || (bus.pc_write_cond && bus.alu_zero))) begin
      case (bus.pc_source)
        2'd0:    n_pc = bus.alu_result & ~32'd3;
        2'd1:    n_pc = m_ao & ~32'd3;
        2'd2:    n_pc = {m_pc[31:28], m_ir[25:0], 2'b00};
        default: n_pc = m_pc;
      endcase
    end
    if (!m_halt && bus.ir_write) begin
      n_ir  = bus.mem_rdata;
      n_cnt = m_cnt + 1;
    end
    if (bus.mem_read && bus.iord) n_mdr = bus.mem_rdata;
`ifdef HALT_EN
    n_halt = m_halt || (m_ir[31:26] == 6'b111111);
`else
    n_halt = 1'b0;
`endif
    @(posedge clk);
    #1;
    m_pc = n_pc; m_ir = n_ir; m_mdr = n_mdr; m_cnt = n_cnt; m_halt = n_halt;
    m_a = bus.rs_data; m_b = bus.rt_data; m_ao = bus.alu_result;
    check_all(tag);
  endtask

  task automatic fetch(input logic [31:0] word, input logic [31:0] next_pc);
    set_idle();
    bus.mem_rdata = word; bus.ir_write = 1; bus.pc_write = 1;
    bus.pc_source = 2'b00; bus.alu_result = next_pc;
  endtask

  initial begin
    logic [31:0] rd;
`ifdef HALT_EN
    logic [31:0] cnt_at_halt;
`endif
    rst = 1'b0;
    set_idle();
    model_reset();
    #2;
    check_all("reset");
    bus.alu_src_a = 1; bus.mem_to_reg = 1;
    #1;
    check_all("reset_regs");
    set_idle();
    @(posedge clk);
    #1;
    rst = 1'b1;

    // lw fetch
    fetch(32'h8C22_0004, 32'd4);
    step("fetch");
    chk("fetch.pc_const", bus.pc, 32'd4);
    chk("fetch.opcode_const", 32'(bus.opcode), 32'(6'b100011));
    chk("fetch.cnt_const", bus.instr_cnt, 32'd1);
    chk("fetch.rs_const", 32'(bus.rs_addr), 32'd1);
    chk("fetch.rt_const", 32'(bus.rt_addr), 32'd2);

    // lw address and memory read
    set_idle(); bus.alu_result = 32'h40;
    step("lw_addr");
    set_idle(); bus.iord = 1; bus.mem_read = 1; bus.mem_rdata = 32'hDEAD_BEEF;
    bus.alu_result = 32'h40;
    #1;
    chk("lw.mem_addr_const", bus.mem_addr, 32'h40);
    chk("lw.mem_rd_const", 32'(bus.mem_rd), 32'd1);
    step("lw_mem");
    set_idle(); bus.mem_to_reg = 1; bus.reg_write = 1; bus.alu_result = 32'h20;
    #1;
    chk("lw.wb_addr_const", 32'(bus.wb_addr), 32'd2);
    chk("lw.wb_data_const", bus.wb_data, 32'hDEAD_BEEF);
    chk("lw.wb_en_const", 32'(bus.wb_en), 32'd1);
    step("lw_wb");

    // beq not taken, then taken
    set_idle(); bus.pc_write_cond = 1; bus.pc_source = 2'b01;
    bus.alu_result = 32'h20; bus.alu_zero = 0;
    step("beq_nt");
    chk("beq_nt.pc_const", bus.pc, 32'd4);
    bus.alu_zero = 1;
    step("beq_t");
    chk("beq_t.pc_const", bus.pc, 32'h20);

    // jump
    fetch(32'h0800_0010, 32'h1000_0004);
    step("j_fetch");
    set_idle(); bus.pc_write = 1; bus.pc_source = 2'b10;
    step("j_exec");
    chk("j.pc_const", bus.pc, 32'h1000_0040);

    // $zero write suppression plus forced alignment
    fetch(32'h2000_0000, 32'h0000_0007);
    step("r0_fetch");
    chk("align.pc_const", bus.pc, 32'h0000_0004);
    set_idle(); bus.reg_write = 1; bus.reg_dst = 0;
    #1;
    chk("r0.wb_en_const", 32'(bus.wb_en), 32'd0);
    step("r0_wb");

    // Reserved PC source holds
    set_idle(); bus.pc_write = 1; bus.pc_source = 2'b11; bus.alu_result = 32'h100;
    step("pcs_rsvd");
    chk("rsvd.pc_const", bus.pc, 32'h0000_0004);

    // Immediate operand forms
    fetch(32'h1000_FFF0, 32'h8);
    step("imm_fetch");
    set_idle(); bus.alu_src_b = 2'b10;
    #1;
    chk("imm.sext_const", bus.alu_b, 32'hFFFF_FFF0);
    bus.alu_src_b = 2'b11;
    #1;
    chk("imm.sh2_const", bus.alu_b, 32'hFFFF_FFC0);
    step("imm_sh2");

`ifdef HALT_EN
    fetch(32'hFC00_0000, 32'h10);
    step("halt_fetch");
    chk("halt.not_yet", 32'(bus.halted), 32'd0);
    set_idle();
    step("halt_set");
    chk("halt.set_const", 32'(bus.halted), 32'd1);
    cnt_at_halt = bus.instr_cnt;
    set_idle(); bus.pc_write = 1; bus.alu_result = 32'h100; bus.mem_read = 1;
    bus.ir_write = 1; bus.mem_rdata = 32'h8C22_0004; bus.reg_write = 1;
    bus.reg_dst = 1; bus.mem_write = 1;
    #1;
    chk("halt.mem_rd_const", 32'(bus.mem_rd), 32'd0);
    chk("halt.mem_wr_const", 32'(bus.mem_wr), 32'd0);
    step("halt_frozen");
    chk("halt.pc_frozen", bus.pc, 32'h10);
    chk("halt.cnt_frozen", bus.instr_cnt, cnt_at_halt);
    chk("halt.ir_frozen", 32'(bus.opcode), 32'(6'b111111));
    rst = 1'b0;
    #1;
    model_reset();
    chk("halt.rst_halted", 32'(bus.halted), 32'd0);
    chk("halt.rst_pc", bus.pc, RST_PC);
    #1;
    rst = 1'b1;
`endif

    // Randomized cycles with an asynchronous reset mid-instruction
    for (int i = 0; i < 200; i++) begin
      rd = $urandom();
      if (rd[31:26] == 6'b111111) rd[31] = 1'b0;
      bus.pc_write      = ($urandom_range(0, 3) == 0);
      bus.pc_write_cond = $urandom_range(0, 1);
      bus.ir_write      = $urandom_range(0, 1);
      bus.iord          = $urandom_range(0, 1);
      bus.mem_read      = $urandom_range(0, 1);
      bus.mem_write     = $urandom_range(0, 1);
      bus.mem_to_reg    = $urandom_range(0, 1);
      bus.reg_dst       = $urandom_range(0, 1);
      bus.reg_write     = $urandom_range(0, 1);
      bus.alu_src_a     = $urandom_range(0, 1);
      bus.alu_src_b     = 2'($urandom_range(0, 3));
      bus.pc_source     = 2'($urandom_range(0, 3));
      bus.mem_rdata     = rd;
      bus.alu_result    = $urandom();
      bus.alu_zero      = $urandom_range(0, 1);
      bus.rs_data       = $urandom();
      bus.rt_data       = $urandom();
      if (i == 120) begin
        rst = 1'b0;
        #1;
        model_reset();
        check_all("mid_reset");
        #1;
        rst = 1'b1;
      end
      step($sformatf("rand%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
`default_nettype wire
